// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM-stage port.
// Hits complete with no added latency; misses write back a dirty victim, fill, then retry.
module dcache_direct #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned INDEX_BITS  = 2
) (
  input  logic                                  Clk,
  input  logic                                  Reset_N,
  input  logic                                  readM,
  input  logic                                  writeM,
  input  logic [WORD_SIZE-1:0]                  address,
  inout  wire  [WORD_SIZE-1:0]                  data,
  output logic                                  busy,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [WORD_SIZE-1:0]                  mem_addr,
  output logic [(WORD_SIZE<<OFFSET_BITS)-1:0]   mem_wdata,
  input  logic [(WORD_SIZE<<OFFSET_BITS)-1:0]   mem_rdata,
  input  logic                                  mem_ready,
  output logic [WORD_SIZE-1:0]                  hit_count,
  output logic [WORD_SIZE-1:0]                  access_count
);

  localparam int unsigned LINE_WORDS = 1 << OFFSET_BITS;
  localparam int unsigned NUM_LINES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS   = WORD_SIZE - OFFSET_BITS - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t                      state;
  logic [NUM_LINES-1:0]        valid;
  logic [NUM_LINES-1:0]        dirty;
  logic [TAG_BITS-1:0]         tag_arr [NUM_LINES];
  logic [WORD_SIZE-1:0]        lines   [NUM_LINES][LINE_WORDS];
  logic                        missed;
  logic [INDEX_BITS-1:0]       miss_index;
  logic [TAG_BITS-1:0]         miss_tag;

  logic [OFFSET_BITS-1:0]      offset;
  logic [INDEX_BITS-1:0]       index;
  logic [TAG_BITS-1:0]         tag;
  logic                        req;
  logic                        hit;
  logic                        done;

  assign offset = address[OFFSET_BITS-1:0];
  assign index  = address[OFFSET_BITS +: INDEX_BITS];
  assign tag    = address[WORD_SIZE-1 -: TAG_BITS];

  assign req  = readM | writeM;
  assign hit  = (state == IDLE) && valid[index] && (tag_arr[index] == tag);
  assign busy = req && !hit;
  assign done = req && hit;

  // Drive read data only on a completing read; writes own the bus otherwise.
  assign data = (readM && !writeM && !busy) ? lines[index][offset] : {WORD_SIZE{1'bz}};

  // Memory-side outputs decode the registered state; miss index/tag are latched so a dropped request is harmless.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WB: begin
        mem_write = 1'b1;
        mem_addr  = {tag_arr[miss_index], miss_index, OFFSET_BITS'(0)};
        for (int k = 0; k < int'(LINE_WORDS); k++) begin
          mem_wdata[k*WORD_SIZE +: WORD_SIZE] = lines[miss_index][OFFSET_BITS'(k)];
        end
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {miss_tag, miss_index, OFFSET_BITS'(0)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      missed       <= 1'b0;
      miss_index   <= '0;
      miss_tag     <= '0;
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            access_count <= access_count + WORD_SIZE'(1);
            if (!missed) hit_count <= hit_count + WORD_SIZE'(1);
            missed <= 1'b0;
            if (writeM) begin
              lines[index][offset] <= data;
              dirty[index]         <= 1'b1;
            end
          end else if (req) begin
            missed     <= 1'b1;
            miss_index <= index;
            miss_tag   <= tag;
            state      <= (valid[index] && dirty[index]) ? WB : FILL;
          end else begin
            missed <= 1'b0;
          end
        end
        WB: begin
          if (mem_ready) begin
            dirty[miss_index] <= 1'b0;
            state             <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            for (int k = 0; k < int'(LINE_WORDS); k++) begin
              lines[miss_index][OFFSET_BITS'(k)] <= mem_rdata[k*WORD_SIZE +: WORD_SIZE];
            end
            tag_arr[miss_index] <= miss_tag;
            valid[miss_index]   <= 1'b1;
            dirty[miss_index]   <= 1'b0;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipelined datapath's MEM-stage port (readM2/writeM2/address2/data2/M2busy) and the slow backing memory.
- Serves CPU-side hits with zero added latency.
- On a miss it asserts busy, writes back a dirty victim line if needed, fills the line, then completes the access.
- Exports hit and access counters for performance reporting.

Parameters:
- WORD_SIZE, 16, CPU word width and address width (word-addressed).
- OFFSET_BITS, 2, log2 of words per line (LINE_WORDS = 4).
- INDEX_BITS, 2, log2 of number of lines (NUM_LINES = 4).

Ports:
- Clk  input  1  clock; all state changes on posedge.
- Reset_N  input  1  synchronous, active-low reset.
- readM  input  1  CPU read request, held until busy low.
- writeM  input  1  CPU write request, held until busy low.
- address  input  WORD_SIZE  CPU word address.
- data  inout  WORD_SIZE  CPU data; cache drives on read completion, else Z.
- busy  output  1  access not completing this cycle.
- mem_read  output  1  line fill request to memory.
- mem_write  output  1  line writeback request to memory.
- mem_addr  output  WORD_SIZE  line-aligned address (offset bits 0).
- mem_wdata  output  WORD_SIZE*LINE_WORDS  victim line, word 0 in LSBs.
- mem_rdata  input  WORD_SIZE*LINE_WORDS  fill line, word 0 in LSBs.
- mem_ready  input  1  one-cycle pulse: current memory op done.
- hit_count  output  WORD_SIZE  completed accesses that hit first cycle.
- access_count  output  WORD_SIZE  completed accesses.

Behaviour:
Address split:
- offset = address[OFFSET_BITS-1:0]
- index = next INDEX_BITS bits
- tag = remaining upper bits
- hit = state==IDLE && valid[index] && tag_arr[index]==tag

Request and busy:
- req = readM | writeM; if both are high, treat as a write.
- busy = req && !hit (combinational). busy=0 when req=0.
- Completion edge: posedge with req && !busy.

Read and write hit:
- data = line[index][offset] when readM && !writeM && !busy; else Z. The datapath samples it at the completion edge.
- Write hit: at completion edge, line[index][offset] <= data and dirty[index] <= 1.

FSM states: IDLE, WB, FILL.
- IDLE: on req && miss:
  - valid && dirty victim -> WB.
  - otherwise -> FILL.
  - In both cases set missed <= 1.
- WB:
  - mem_write=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
  - On mem_ready -> FILL; dirty[index] <= 0.
- FILL:
  - mem_read=1, mem_addr={tag, index, 0}.
  - On mem_ready: line <= mem_rdata, tag_arr <= tag, valid <= 1, dirty <= 0; -> IDLE.
  - The held request hits the cycle after returning to IDLE; a miss costs fill (+writeback) latency + 1 cycle.
- mem_read and mem_write are Moore decodes of state; never both high. mem_addr and mem_wdata are 0 in IDLE.

Counters:
- At each completion edge: access_count += 1.
- hit_count += 1 iff missed==0; then missed <= 0.
- Both wrap modulo 2^WORD_SIZE.

Boundary cases:
- Request dropped mid-miss: the memory transaction still completes and the line is installed; no counter update; missed cleared on return to IDLE when req=0.
- mem_ready in IDLE is ignored.
- Back-to-back accesses with req held and address changing each cycle are each counted.
- Write miss: allocate (fill) first, then write at the completion edge; the line ends dirty.

Reset (Reset_N=0 at posedge, including mid-WB/FILL):
- state <= IDLE; all valid and dirty bits <= 0; missed <= 0; counters <= 0.
- mem_read and mem_write low from the next cycle.
- An in-flight memory op is abandoned; a later mem_ready is ignored.

Test Plan:
Memory model for all scenarios: returns word k of a line as 0x1000+addr+k, with 3-cycle latency.
1. After reset, read 0x0005:
   - mem_read=1 with mem_addr=0x0004.
   - busy=1 until the cycle after mem_ready, then busy=0 and data=0x1005.
   - access_count=1, hit_count=0.
2. Read 0x0006 next cycle:
   - busy=0 in the same cycle, data=0x1006, mem_read stays 0.
   - hit_count=1, access_count=2.
3. Write 0x0006 with 0xBEEF, then read 0x0006:
   - Both complete with busy=0; the read returns 0xBEEF.
   - mem_write never asserted.
4. Read 0x0016 (index 1, tag 1), conflicting with the dirty line:
   - mem_write first with mem_addr=0x0004 and mem_wdata word2=0xBEEF.
   - Then mem_read with mem_addr=0x0014.
   - Final data=0x1016.
5. Read 0x0026 evicting the now-clean line:
   - No mem_write; mem_read mem_addr=0x0024 directly.
   - data=0x1026.
6. Assert Reset_N=0 for one cycle during FILL:
   - Next cycle mem_read=0 and both counters=0.
   - A subsequent read of 0x0005 misses again: mem_read with mem_addr=0x0004.
